// File: rtl/decode_pkg.sv
// Shared RV64I decode constants, ALU op and immediate-type encodings, decoded-field struct.
package decode_pkg;

   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

   localparam logic [31:0] INST_EBREAK  = 32'h0010_0073;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_SLL   = 4'd2,
      ALU_SLT   = 4'd3,
      ALU_SLTU  = 4'd4,
      ALU_XOR   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_SRA   = 4'd7,
      ALU_OR    = 4'd8,
      ALU_AND   = 4'd9,
      ALU_PASSB = 4'd10
   } alu_op_e;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5
   } imm_type_e;

   typedef struct packed {
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      alu_op_e    alu_op;
      logic       need_imm;
      logic       reg_wen;
      logic       mem_wen;
      logic [7:0] wmask;
      logic       is_load;
      logic       load_signed;
      logic       is_jal;
      logic       is_jalr;
      logic       is_branch;
      logic       is_ebreak;
      logic       word;
      logic       illegal;
   } dec_t;

   // 32-bit sign-extended immediate; callers widen to XLEN by replicating bit 31.
   function automatic logic [31:0] imm32(input logic [31:0] inst, input imm_type_e t);
      case (t)
         IMM_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
         IMM_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         IMM_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         IMM_U:   imm32 = {inst[31:12], 12'b0};
         IMM_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         default: imm32 = 32'b0;
      endcase
   endfunction

   function automatic alu_op_e alu_f3(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  alu_f3 = alt ? ALU_SUB : ALU_ADD;
         3'b001:  alu_f3 = ALU_SLL;
         3'b010:  alu_f3 = ALU_SLT;
         3'b011:  alu_f3 = ALU_SLTU;
         3'b100:  alu_f3 = ALU_XOR;
         3'b101:  alu_f3 = alt ? ALU_SRA : ALU_SRL;
         3'b110:  alu_f3 = ALU_OR;
         default: alu_f3 = ALU_AND;
      endcase
   endfunction

   function automatic logic [7:0] store_wmask(input logic [1:0] size);
      case (size)
         2'b00:   store_wmask = 8'h01;
         2'b01:   store_wmask = 8'h03;
         2'b10:   store_wmask = 8'h0F;
         default: store_wmask = 8'hFF;
      endcase
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage; slave = stage, master = neighbours.
interface decode_stage_if #(parameter int XLEN = 64);

   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_inst;
   logic [XLEN-1:0] in_pc;

   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [4:0]      out_rd;
   logic [4:0]      out_rs1;
   logic [4:0]      out_rs2;
   logic [XLEN-1:0] out_imm;
   logic [3:0]      out_alu_op;
   logic            out_need_imm;
   logic            out_reg_wen;
   logic            out_mem_wen;
   logic [7:0]      out_wmask;
   logic            out_is_load;
   logic            out_load_signed;
   logic            out_is_jal;
   logic            out_is_jalr;
   logic            out_is_branch;
   logic            out_is_ebreak;
   logic            out_word;
   logic            out_illegal;

   modport slave (
      input  in_valid, in_inst, in_pc, out_ready,
      output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm,
             out_alu_op, out_need_imm, out_reg_wen, out_mem_wen, out_wmask,
             out_is_load, out_load_signed, out_is_jal, out_is_jalr, out_is_branch,
             out_is_ebreak, out_word, out_illegal
   );

   modport master (
      output in_valid, in_inst, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm,
             out_alu_op, out_need_imm, out_reg_wen, out_mem_wen, out_wmask,
             out_is_load, out_load_signed, out_is_jal, out_is_jalr, out_is_branch,
             out_is_ebreak, out_word, out_illegal
   );

endinterface

// File: rtl/decode_comb.sv
// Pure combinational RV64I field decoder, zero latency, no handshake.
// DECODE_STAGE_RV64W_EN enables the *W word ops; otherwise they decode as illegal.
module decode_comb
   import decode_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [31:0]     i_inst,
   output dec_t            o_dec,
   output logic [XLEN-1:0] o_imm
);

`ifdef DECODE_STAGE_RV64W_EN
   localparam logic RV64W_EN = 1'b1;
`else
   localparam logic RV64W_EN = 1'b0;
`endif

   logic [6:0]  w_opc;
   logic [2:0]  w_f3;
   logic        w_base;
   logic        w_alt;
   logic        w_legal;
   logic        w_wr;
   imm_type_e   w_imm_t;
   logic [31:0] w_imm32;

   assign w_opc   = i_inst[6:0];
   assign w_f3    = i_inst[14:12];
   assign w_base  = (i_inst[31:25] == 7'b0000000);
   assign w_alt   = (i_inst[31:25] == 7'b0100000);
   assign w_imm32 = imm32(i_inst, w_imm_t);
   assign o_imm   = {{(XLEN-32){w_imm32[31]}}, w_imm32};

   always_comb begin
      o_dec        = '0;
      o_dec.rd     = i_inst[11:7];
      o_dec.rs1    = i_inst[19:15];
      o_dec.rs2    = i_inst[24:20];
      o_dec.alu_op = ALU_ADD;
      w_imm_t      = IMM_NONE;
      w_legal      = 1'b0;
      w_wr         = 1'b0;
      case (w_opc)
         OPC_LUI: begin
            w_legal = 1'b1; w_wr = 1'b1; w_imm_t = IMM_U;
            o_dec.need_imm = 1'b1; o_dec.alu_op = ALU_PASSB;
         end
         OPC_AUIPC: begin
            w_legal = 1'b1; w_wr = 1'b1; w_imm_t = IMM_U;
            o_dec.need_imm = 1'b1;
         end
         OPC_JAL: begin
            w_legal = 1'b1; w_wr = 1'b1; w_imm_t = IMM_J;
            o_dec.is_jal = 1'b1;
         end
         OPC_JALR: begin
            w_legal = (w_f3 == 3'b000); w_wr = 1'b1; w_imm_t = IMM_I;
            o_dec.need_imm = 1'b1; o_dec.is_jalr = 1'b1;
         end
         OPC_BRANCH: begin
            // Comparison is carried by the ALU op: SUB for EQ/NE, SLT(U) for ordered compares.
            w_legal = (w_f3[2:1] != 2'b01); w_imm_t = IMM_B;
            o_dec.is_branch = 1'b1;
            o_dec.alu_op    = w_f3[2] ? (w_f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
         end
         OPC_LOAD: begin
            w_legal = (w_f3 != 3'b111); w_wr = 1'b1; w_imm_t = IMM_I;
            o_dec.need_imm = 1'b1; o_dec.is_load = 1'b1;
            o_dec.load_signed = ~w_f3[2];
         end
         OPC_STORE: begin
            w_legal = ~w_f3[2]; w_imm_t = IMM_S;
            o_dec.need_imm = 1'b1; o_dec.mem_wen = 1'b1;
            o_dec.wmask = store_wmask(w_f3[1:0]);
         end
         OPC_OP_IMM: begin
            // RV64 shift amounts are 6 bits, so only inst[31:26] qualifies the shift kind.
            w_legal = (w_f3 == 3'b001) ? (i_inst[31:26] == 6'b000000) :
                      (w_f3 == 3'b101) ? (i_inst[31:26] == 6'b000000 || i_inst[31:26] == 6'b010000) :
                      1'b1;
            w_wr = 1'b1; w_imm_t = IMM_I; o_dec.need_imm = 1'b1;
            o_dec.alu_op = alu_f3(w_f3, i_inst[30] & (w_f3 == 3'b101));
         end
         OPC_OP: begin
            w_legal = (w_f3 == 3'b000 || w_f3 == 3'b101) ? (w_base | w_alt) : w_base;
            w_wr = 1'b1;
            o_dec.alu_op = alu_f3(w_f3, w_alt);
         end
         OPC_OP_IMM_32: begin
            w_legal = RV64W_EN & ((w_f3 == 3'b000) |
                                  ((w_f3 == 3'b001) & w_base) |
                                  ((w_f3 == 3'b101) & (w_base | w_alt)));
            w_wr = 1'b1; w_imm_t = IMM_I; o_dec.need_imm = 1'b1;
            o_dec.word   = RV64W_EN;
            o_dec.alu_op = alu_f3(w_f3, i_inst[30] & (w_f3 == 3'b101));
         end
         OPC_OP_32: begin
            w_legal = RV64W_EN & ((((w_f3 == 3'b000) | (w_f3 == 3'b101)) & (w_base | w_alt)) |
                                  ((w_f3 == 3'b001) & w_base));
            w_wr = 1'b1;
            o_dec.word   = RV64W_EN;
            o_dec.alu_op = alu_f3(w_f3, w_alt);
         end
         OPC_SYSTEM: begin
            w_legal = (i_inst == INST_EBREAK);
            o_dec.is_ebreak = w_legal;
         end
         default: begin
            // All-zero word is the pipeline bubble: legal, nothing enabled.
            w_legal = (i_inst == 32'h0000_0000);
         end
      endcase

      o_dec.reg_wen = w_wr & (o_dec.rd != 5'd0);

      if (!w_legal) begin
         o_dec.reg_wen     = 1'b0;
         o_dec.mem_wen     = 1'b0;
         o_dec.wmask       = 8'h00;
         o_dec.is_load     = 1'b0;
         o_dec.load_signed = 1'b0;
         o_dec.is_jal      = 1'b0;
         o_dec.is_jalr     = 1'b0;
         o_dec.is_branch   = 1'b0;
         o_dec.is_ebreak   = 1'b0;
         o_dec.word        = 1'b0;
         o_dec.illegal     = 1'b1;
      end
   end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: output register + skid entry, 1-cycle latency, flush and accept counter.
// Backpressure: in_ready is registered (skid empty), so a stalled output absorbs one more beat.
module decode_stage #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   decode_stage_if.slave    bus,
   output logic [CNT_W-1:0] decode_cnt
);
   import decode_pkg::*;

   dec_t             w_dec;
   logic [XLEN-1:0]  w_imm;
   logic             w_in_fire;
   logic             w_out_fire;
   logic             w_out_free;

   dec_t             r_out_dec;
   logic [XLEN-1:0]  r_out_pc;
   logic [XLEN-1:0]  r_out_imm;
   logic             r_out_vld;
   dec_t             r_skid_dec;
   logic [XLEN-1:0]  r_skid_pc;
   logic [XLEN-1:0]  r_skid_imm;
   logic             r_skid_vld;
   logic             r_in_rdy;
   logic [CNT_W-1:0] r_cnt;

   decode_comb #(.XLEN(XLEN)) u_comb (
      .i_inst (bus.in_inst),
      .o_dec  (w_dec),
      .o_imm  (w_imm)
   );

   assign w_in_fire  = bus.in_valid & r_in_rdy;
   assign w_out_fire = r_out_vld & bus.out_ready;
   assign w_out_free = ~r_out_vld | w_out_fire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_dec  <= '0;
         r_out_pc   <= '0;
         r_out_imm  <= '0;
         r_out_vld  <= 1'b0;
         r_skid_dec <= '0;
         r_skid_pc  <= '0;
         r_skid_imm <= '0;
         r_skid_vld <= 1'b0;
         r_in_rdy   <= 1'b0;
         r_cnt      <= '0;
      end else if (flush) begin
         r_out_vld  <= 1'b0;
         r_skid_vld <= 1'b0;
         r_in_rdy   <= 1'b1;
      end else begin
         if (w_out_fire) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_out_free) begin
            // Skid holds the older beat; it drains first. in_ready was low, so no new beat now.
            r_in_rdy <= 1'b1;
            if (r_skid_vld) begin
               r_out_dec  <= r_skid_dec;
               r_out_pc   <= r_skid_pc;
               r_out_imm  <= r_skid_imm;
               r_out_vld  <= 1'b1;
               r_skid_vld <= 1'b0;
            end else if (w_in_fire) begin
               r_out_dec  <= w_dec;
               r_out_pc   <= bus.in_pc;
               r_out_imm  <= w_imm;
               r_out_vld  <= 1'b1;
            end else begin
               r_out_vld  <= 1'b0;
            end
         end else if (w_in_fire) begin
            r_skid_dec <= w_dec;
            r_skid_pc  <= bus.in_pc;
            r_skid_imm <= w_imm;
            r_skid_vld <= 1'b1;
            r_in_rdy   <= 1'b0;
         end
      end
   end

   assign bus.in_ready        = r_in_rdy;
   assign bus.out_valid       = r_out_vld;
   assign bus.out_pc          = r_out_pc;
   assign bus.out_imm         = r_out_imm;
   assign bus.out_rd          = r_out_dec.rd;
   assign bus.out_rs1         = r_out_dec.rs1;
   assign bus.out_rs2         = r_out_dec.rs2;
   assign bus.out_alu_op      = r_out_dec.alu_op;
   assign bus.out_need_imm    = r_out_dec.need_imm;
   assign bus.out_reg_wen     = r_out_dec.reg_wen;
   assign bus.out_mem_wen     = r_out_dec.mem_wen;
   assign bus.out_wmask       = r_out_dec.wmask;
   assign bus.out_is_load     = r_out_dec.is_load;
   assign bus.out_load_signed = r_out_dec.load_signed;
   assign bus.out_is_jal      = r_out_dec.is_jal;
   assign bus.out_is_jalr     = r_out_dec.is_jalr;
   assign bus.out_is_branch   = r_out_dec.is_branch;
   assign bus.out_is_ebreak   = r_out_dec.is_ebreak;
   assign bus.out_word        = r_out_dec.word;
   assign bus.out_illegal     = r_out_dec.illegal;
   assign decode_cnt          = r_cnt;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vectors, backpressure, flush and reset abort.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] decode_cnt;
   int          n_vec = 0;
   int          n_err = 0;

   decode_stage_if #(.XLEN(64)) bus ();

   decode_stage #(.XLEN(64), .CNT_W(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .bus        (bus),
      .decode_cnt (decode_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] inst, input logic [63:0] pc);
      bus.in_valid = 1'b1;
      bus.in_inst  = inst;
      bus.in_pc    = pc;
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      bus.in_valid = 1'b1; bus.in_inst = 32'h0050_0093; bus.in_pc = 64'h0; bus.out_ready = 1'b0;
      rst_n = 1'b0;
      tick(); tick();
      n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
      n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
      n_vec++; if (decode_cnt !== 32'd0) begin n_err++; $display("FAIL rst_cnt: got %0d want 0", decode_cnt); end
      n_vec++; if (bus.out_rd !== 5'd0 || bus.out_imm !== 64'd0 || bus.out_pc !== 64'd0) begin
         n_err++; $display("FAIL rst_fields: got rd=%0d imm=%h pc=%h want all 0", bus.out_rd, bus.out_imm, bus.out_pc); end
      bus.in_valid = 1'b0;
      rst_n = 1'b1;
      n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL rel_in_ready_pre: got %b want 0", bus.in_ready); end
      tick();
      n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rel_in_ready_post: got %b want 1", bus.in_ready); end
      n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rel_out_valid: got %b want 0", bus.out_valid); end
   endtask

   task automatic test_addi();
      send(32'h0050_0093, 64'h1000);
      n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL addi_valid: got %b want 1", bus.out_valid); end
      n_vec++; if (bus.out_rd !== 5'd1 || bus.out_rs1 !== 5'd0) begin n_err++; $display("FAIL addi_regs: got rd=%0d rs1=%0d want 1,0", bus.out_rd, bus.out_rs1); end
      n_vec++; if (bus.out_imm !== 64'd5) begin n_err++; $display("FAIL addi_imm: got %h want 5", bus.out_imm); end
      n_vec++; if (bus.out_alu_op !== 4'd0 || bus.out_need_imm !== 1'b1) begin n_err++; $display("FAIL addi_alu: got op=%0d ni=%b want 0,1", bus.out_alu_op, bus.out_need_imm); end
      n_vec++; if (bus.out_reg_wen !== 1'b1 || bus.out_illegal !== 1'b0) begin n_err++; $display("FAIL addi_wen: got wen=%b ill=%b want 1,0", bus.out_reg_wen, bus.out_illegal); end
      n_vec++; if (bus.out_pc !== 64'h1000) begin n_err++; $display("FAIL addi_pc: got %h want 1000", bus.out_pc); end
      n_vec++; if (decode_cnt !== 32'd0) begin n_err++; $display("FAIL addi_cnt_pre: got %0d want 0", decode_cnt); end
      drain();
      n_vec++; if (decode_cnt !== 32'd1) begin n_err++; $display("FAIL addi_cnt_post: got %0d want 1", decode_cnt); end
      n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL addi_drained: got %b want 0", bus.out_valid); end
   endtask

   task automatic test_store();
      send(32'h0020_B423, 64'h1004);
      n_vec++; if (bus.out_mem_wen !== 1'b1 || bus.out_wmask !== 8'hFF) begin n_err++; $display("FAIL sd_mem: got wen=%b mask=%h want 1,ff", bus.out_mem_wen, bus.out_wmask); end
      n_vec++; if (bus.out_imm !== 64'd8) begin n_err++; $display("FAIL sd_imm: got %h want 8", bus.out_imm); end
      n_vec++; if (bus.out_reg_wen !== 1'b0 || bus.out_is_load !== 1'b0) begin n_err++; $display("FAIL sd_wen: got wen=%b ld=%b want 0,0", bus.out_reg_wen, bus.out_is_load); end
      n_vec++; if (bus.out_rs1 !== 5'd1 || bus.out_rs2 !== 5'd2) begin n_err++; $display("FAIL sd_regs: got rs1=%0d rs2=%0d want 1,2", bus.out_rs1, bus.out_rs2); end
      drain();
   endtask

   task automatic test_control_flow();
      send(32'h0080_00EF, 64'h2000);   // jal x1, 8
      n_vec++; if (bus.out_is_jal !== 1'b1 || bus.out_imm !== 64'd8 || bus.out_reg_wen !== 1'b1) begin
         n_err++; $display("FAIL jal: got jal=%b imm=%h wen=%b want 1,8,1", bus.out_is_jal, bus.out_imm, bus.out_reg_wen); end
      drain();
      send(32'hFE20_9EE3, 64'h2004);   // bne x1, x2, -4
      n_vec++; if (bus.out_is_branch !== 1'b1 || bus.out_imm !== 64'hFFFF_FFFF_FFFF_FFFC) begin
         n_err++; $display("FAIL bne_imm: got br=%b imm=%h want 1,fffffffffffffffc", bus.out_is_branch, bus.out_imm); end
      n_vec++; if (bus.out_alu_op !== 4'd1 || bus.out_reg_wen !== 1'b0 || bus.out_need_imm !== 1'b0) begin
         n_err++; $display("FAIL bne_ctl: got op=%0d wen=%b ni=%b want 1,0,0", bus.out_alu_op, bus.out_reg_wen, bus.out_need_imm); end
      drain();
      send(32'h0030_C283, 64'h2008);   // lbu x5, 3(x1)
      n_vec++; if (bus.out_is_load !== 1'b1 || bus.out_load_signed !== 1'b0 || bus.out_imm !== 64'd3 || bus.out_rd !== 5'd5) begin
         n_err++; $display("FAIL lbu: got ld=%b sg=%b imm=%h rd=%0d want 1,0,3,5", bus.out_is_load, bus.out_load_signed, bus.out_imm, bus.out_rd); end
      drain();
      send(32'h0010_8013, 64'h200C);   // addi x0, x1, 1
      n_vec++; if (bus.out_reg_wen !== 1'b0 || bus.out_illegal !== 1'b0) begin
         n_err++; $display("FAIL rd_x0: got wen=%b ill=%b want 0,0", bus.out_reg_wen, bus.out_illegal); end
      drain();
   endtask

   task automatic test_back_to_back();
      n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready0: got %b want 1", bus.in_ready); end
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.in_inst = 32'h00A0_0113; bus.in_pc = 64'h3000;
      tick();
      n_vec++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_first: got v=%b r=%b want 1,1", bus.out_valid, bus.in_ready); end
      bus.in_inst = 32'h00B0_0193; bus.in_pc = 64'h3004;
      tick();
      n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full: got in_ready %b want 0", bus.in_ready); end
      bus.in_inst = 32'h00C0_0213; bus.in_pc = 64'h3008;
      tick();
      n_vec++; if (bus.out_rd !== 5'd2 || bus.out_imm !== 64'd10 || bus.out_pc !== 64'h3000 || bus.in_ready !== 1'b0) begin
         n_err++; $display("FAIL b2b_hold: got rd=%0d imm=%h pc=%h r=%b want 2,a,3000,0", bus.out_rd, bus.out_imm, bus.out_pc, bus.in_ready); end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      n_vec++; if (bus.out_valid !== 1'b1 || bus.out_rd !== 5'd3 || bus.out_imm !== 64'd11 || bus.out_pc !== 64'h3004) begin
         n_err++; $display("FAIL b2b_second: got v=%b rd=%0d imm=%h pc=%h want 1,3,b,3004", bus.out_valid, bus.out_rd, bus.out_imm, bus.out_pc); end
      n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready1: got %b want 1", bus.in_ready); end
      tick();
      bus.out_ready = 1'b0;
      n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_dup: got out_valid %b want 0", bus.out_valid); end
      n_vec++; if (decode_cnt !== 32'd8) begin n_err++; $display("FAIL b2b_cnt: got %0d want 8", decode_cnt); end
   endtask

   task automatic test_flush();
      send(32'h00A0_0113, 64'h4000);
      send(32'h00B0_0193, 64'h4004);
      n_vec++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin n_err++; $display("FAIL fl_full: got r=%b v=%b want 0,1", bus.in_ready, bus.out_valid); end
      flush = 1'b1; bus.out_ready = 1'b1;
      tick();
      flush = 1'b0; bus.out_ready = 1'b0;
      n_vec++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_err++; $display("FAIL fl_empty: got v=%b r=%b want 0,1", bus.out_valid, bus.in_ready); end
      n_vec++; if (decode_cnt !== 32'd8) begin n_err++; $display("FAIL fl_cnt: got %0d want 8", decode_cnt); end
      flush = 1'b1;
      send(32'h0050_0093, 64'h4008);
      flush = 1'b0;
      n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL fl_input: got out_valid %b want 0", bus.out_valid); end
      tick();
      n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL fl_ghost: got out_valid %b want 0", bus.out_valid); end
   endtask

   task automatic test_illegal();
      send(32'hFFFF_FFFF, 64'h5000);
      n_vec++; if (bus.out_illegal !== 1'b1 || bus.out_reg_wen !== 1'b0 || bus.out_mem_wen !== 1'b0) begin
         n_err++; $display("FAIL ill: got ill=%b wen=%b mwen=%b want 1,0,0", bus.out_illegal, bus.out_reg_wen, bus.out_mem_wen); end
      drain();
      send(32'h0000_0000, 64'h5004);
      n_vec++; if (bus.out_valid !== 1'b1 || bus.out_illegal !== 1'b0 || bus.out_reg_wen !== 1'b0 || bus.out_mem_wen !== 1'b0 || bus.out_wmask !== 8'h00) begin
         n_err++; $display("FAIL nop: got v=%b ill=%b wen=%b mwen=%b mask=%h want 1,0,0,0,00", bus.out_valid, bus.out_illegal, bus.out_reg_wen, bus.out_mem_wen, bus.out_wmask); end
      drain();
      n_vec++; if (decode_cnt !== 32'd10) begin n_err++; $display("FAIL ill_cnt: got %0d want 10", decode_cnt); end
   endtask

   task automatic test_rv64w();
      send(32'hFFF0_809B, 64'h6000);   // addiw x1, x1, -1
`ifdef DECODE_STAGE_RV64W_EN
      n_vec++; if (bus.out_illegal !== 1'b0 || bus.out_word !== 1'b1 || bus.out_imm !== 64'hFFFF_FFFF_FFFF_FFFF || bus.out_reg_wen !== 1'b1) begin
         n_err++; $display("FAIL addiw: got ill=%b word=%b imm=%h wen=%b want 0,1,ffffffffffffffff,1", bus.out_illegal, bus.out_word, bus.out_imm, bus.out_reg_wen); end
`else
      n_vec++; if (bus.out_illegal !== 1'b1 || bus.out_word !== 1'b0 || bus.out_reg_wen !== 1'b0) begin
         n_err++; $display("FAIL addiw: got ill=%b word=%b wen=%b want 1,0,0", bus.out_illegal, bus.out_word, bus.out_reg_wen); end
`endif
      drain();
   endtask

   task automatic test_reset_abort();
      send(32'h00A0_0113, 64'h7000);
      send(32'h00B0_0193, 64'h7004);
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || decode_cnt !== 32'd0) begin
         n_err++; $display("FAIL abort: got v=%b r=%b cnt=%0d want 0,0,0", bus.out_valid, bus.in_ready, decode_cnt); end
      tick();
      rst_n = 1'b1;
      tick();
      bus.out_ready = 1'b1;
      tick();
      n_vec++; if (bus.out_valid !== 1'b0 || decode_cnt !== 32'd0) begin
         n_err++; $display("FAIL abort_drain: got v=%b cnt=%0d want 0,0", bus.out_valid, decode_cnt); end
      bus.out_ready = 1'b0;
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_inst   = 32'h0;
      bus.in_pc     = 64'h0;
      bus.out_ready = 1'b0;
      test_reset();
      test_addi();
      test_store();
      test_control_flow();
      test_back_to_back();
      test_flush();
      test_illegal();
      test_rv64w();
      test_reset_abort();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath/PC/immediate width.
REQ-002 SHALL have parameter CNT_W, default 32, decoded-instruction counter width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port flush  input  1  discard all buffered instructions.
REQ-006 SHALL have ports in_valid input 1, in_ready output 1  fetch-side handshake.
REQ-007 SHALL have ports in_inst input 32, in_pc input XLEN  fetched instruction and its PC.
REQ-008 SHALL have ports out_valid output 1, out_ready input 1  execute-side handshake.
REQ-009 SHALL have ports out_pc output XLEN, out_rd/out_rs1/out_rs2 output 5 each, out_imm output XLEN (sign-extended).
REQ-010 SHALL have ports out_alu_op output 4, out_need_imm, out_reg_wen, out_mem_wen output 1 each, out_wmask output 8.
REQ-011 SHALL have ports out_is_load, out_load_signed, out_is_jal, out_is_jalr, out_is_branch, out_is_ebreak, out_word, out_illegal output 1 each.
REQ-012 SHALL have port decode_cnt  output CNT_W  count of instructions accepted downstream.

Function
REQ-013 SHALL decode RV64I: LUI, AUIPC, JAL, JALR, BEQ..BGEU, LB..LD, LBU/LHU/LWU, SB..SD, OP-IMM, OP, EBREAK; imm by I/S/B/U/J type.
REQ-014 SHALL register decoded fields: latency exactly 1 cycle from in_valid&in_ready to out_valid with empty pipeline.
REQ-015 SHALL hold a 2-entry buffer (output register + skid); in_ready = skid entry empty, driven from a register only.
REQ-016 SHALL keep all out_* stable while out_valid&~out_ready; order strictly preserved, no loss, no duplication.
REQ-017 SHALL set out_wmask unshifted: byte 0x01, half 0x03, word 0x0F, double 0xFF; 0x00 for non-stores.
REQ-018 SHALL treat in_inst 0x00000000 as NOP: legal, all enables 0.
REQ-019 SHALL, for any unrecognised encoding, assert out_illegal with reg_wen, mem_wen, jump/branch flags forced 0.
REQ-020 SHALL force out_reg_wen 0 when rd is x0.
REQ-021 SHALL, on flush, empty both entries at the next edge (out_valid 0, in_ready 1 next cycle); flush beats a simultaneous input or output handshake.
REQ-022 SHALL increment decode_cnt on each out_valid&out_ready, wrapping all-ones to 0; flushed instructions are not counted.

Reset
REQ-023 SHALL on rst_n low clear out_valid, skid entry, decode_cnt and all out_* fields to 0 and drive in_ready 0 until the first edge after release.
REQ-024 SHALL abort any buffered instruction when reset asserts mid-operation.

Configuration
REQ-025 SHALL with DECODE_STAGE_RV64W_EN defined decode ADDIW/SLLIW/SRLIW/SRAIW/ADDW/SUBW/SLLW/SRLW/SRAW with out_word 1; without it those are illegal and out_word is tied 0.

Structure
REQ-026 SHALL place opcode constants, ALU op encoding (ADD,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND,PASSB) and imm-type enum in shared package decode_pkg.
REQ-027 SHALL split the pure combinational field decoder into sub-module decode_comb; decode_stage owns buffering, flush and counter.

Verification
REQ-028 SHALL test: 0x00500093 (addi x1,x0,5) -> next cycle out_valid, rd=1, rs1=0, imm=5, alu ADD, reg_wen 1, decode_cnt 1 after accept.
REQ-029 SHALL test: 0x0020B423 (sd x2,8(x1)) -> mem_wen 1, wmask 0xFF, imm 8, reg_wen 0.
REQ-030 SHALL test: out_ready 0 for 3 cycles while two instructions sent -> in_ready 0 after second, both delivered in order once out_ready 1.
REQ-031 SHALL test: flush with both entries full -> next cycle out_valid 0, in_ready 1, decode_cnt unchanged.
REQ-032 SHALL test: 0xFFFFFFFF -> out_illegal 1, reg_wen 0, mem_wen 0.
REQ-033 SHALL test: 0xFFF0809B (addiw x1,x1,-1) -> legal, out_word 1, imm all-ones with macro; out_illegal 1 without.
